fft_frame_feeder: RTL and testbench

Stream-to-frame transmitter that drives the sample-load side of the 8-point FFT core. It accepts complex samples from an upstream valid/ready stream and assembles them into 8-sample frames in a ping-pong buffer. It then issues each frame to the core as a one-cycle start pulse followed by 8 contiguous valid beats, and holds the next frame until the core reports done. Sits between the sample source and the FFT core input port.

---
 rtl/fft_io_pkg.sv | 20 ++
 rtl/fft_frame_buf.sv | 29 ++
 rtl/fft_frame_feeder.sv | 181 ++++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_io_pkg.sv
// Shared constants and types for the FFT sample-load path.
package fft_io_pkg;

    localparam int FRAME_N  = 8;
    localparam int IDX_W    = 3;
    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        WAIT_DONE
    } send_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } sample_t;

endpackage

// File: rtl/fft_frame_buf.sv
// Ping-pong sample store: two banks of FRAME_N complex entries,
// one synchronous write port and one combinational read port.
module fft_frame_buf
    import fft_io_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W:0]    i_waddr,
    input  logic [2*DW-1:0]   i_wdata,
    input  logic [IDX_W:0]    i_raddr,
    output logic [2*DW-1:0]   o_rdata
);

    logic [2*DW-1:0] mem_q [2*FRAME_N];

    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values. The array has no reset: the full flags alone say which
    // entries hold a valid frame, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fft_frame_feeder.sv
// Assembles upstream samples into 8-sample ping-pong frames and issues each
// to the FFT core as start pulse + 8 contiguous beats, gated by core done.
module fft_frame_feeder
    import fft_io_pkg::*;
#(
    parameter int DW           = 32,
    parameter int DONE_TIMEOUT = 256
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    input  logic          s_last,
    output logic          o_start,
    output logic          o_valid,
    output logic [DW-1:0] o_re,
    output logic [DW-1:0] o_im,
    input  logic          i_done,
    output logic          o_busy,
    output logic          o_frame_err,
    output logic          o_timeout
);

    localparam int               TMO_W    = $clog2(DONE_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_N - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(DONE_TIMEOUT - 1);

    send_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       full_q, full_d;
    logic             fill_ptr_q, fill_ptr_d;
    logic             send_ptr_q, send_ptr_d;
    logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout_q, timeout_d;
    logic [DW-1:0]    re_q, re_d;
    logic [DW-1:0]    im_q, im_d;

    logic             accept;
    logic             release_bank;
    logic [IDX_W:0]   rd_addr;
    logic [2*DW-1:0]  rd_data;

    assign s_ready = !i_rst && !full_q[fill_ptr_q];
    assign accept  = s_valid && s_ready;

    fft_frame_buf #(.DW(DW)) u_buf (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_waddr ({fill_ptr_q, fill_cnt_q}),
        .i_wdata ({s_re, s_im}),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        full_d      = full_q;
        fill_ptr_d  = fill_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        frame_err_d = 1'b0;
        if (accept) begin
            if (fill_cnt_q == LAST_IDX) begin
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = ~fill_ptr_q;
                fill_cnt_d         = '0;
                frame_err_d        = !s_last;
            end else if (s_last) begin
                // Early last: drop the partial frame and restart the bank.
                fill_cnt_d  = '0;
                frame_err_d = 1'b1;
            end else begin
                fill_cnt_d = fill_cnt_q + IDX_W'(1);
            end
        end
        if (release_bank) begin
            full_d[send_ptr_q] = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        send_ptr_d   = send_ptr_q;
        release_bank = 1'b0;
        timeout_d    = timeout_q;
        re_d         = re_q;
        im_d         = im_q;
        case (state_q)
            IDLE: begin
                if (full_q[send_ptr_q]) state_d = START;
            end
            START: begin
                state_d = SEND;
                idx_d   = '0;
            end
            SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = WAIT_DONE;
                    tmo_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT_DONE: begin
                if (i_done) begin
                    release_bank = 1'b1;
                end else if (tmo_q == TMO_MAX) begin
                    release_bank = 1'b1;
                    timeout_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_bank) begin
            send_ptr_d = ~send_ptr_q;
            state_d    = IDLE;
        end
        // Outputs are registered from the next state so they line up with it.
        start_d = (state_d == START);
        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        rd_addr = {send_ptr_q, idx_d};
        if (valid_d) begin
            {re_d, im_d} = rd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            full_q      <= '0;
            fill_ptr_q  <= 1'b0;
            send_ptr_q  <= 1'b0;
            fill_cnt_q  <= '0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            full_q      <= full_d;
            fill_ptr_q  <= fill_ptr_d;
            send_ptr_q  <= send_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            re_q        <= re_d;
            im_q        <= im_d;
        end
    end

    assign o_start     = start_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
    assign o_timeout   = timeout_q;
    assign o_re        = re_q;
    assign o_im        = im_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: driver pushes expected beats into a
// scoreboard, a negedge monitor pops and compares them as the core side sees them.
module tb_fft_frame_feeder;
    import fft_io_pkg::*;

    localparam int DW           = 32;
    localparam int DONE_TIMEOUT = 16;
    localparam logic [31:0] FLOATS [8] = '{
        32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
        32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000
    };

    logic          clk = 1'b0;
    logic          i_rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_re;
    logic [DW-1:0] s_im;
    logic          s_last;
    logic          o_start;
    logic          o_valid;
    logic [DW-1:0] o_re;
    logic [DW-1:0] o_im;
    logic          i_done;
    logic          o_busy;
    logic          o_frame_err;
    logic          o_timeout;

    fft_frame_feeder #(.DW(DW), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_re        (s_re),
        .s_im        (s_im),
        .s_last      (s_last),
        .o_start     (o_start),
        .o_valid     (o_valid),
        .o_re        (o_re),
        .o_im        (o_im),
        .i_done      (i_done),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int      n_checks = 0;
    int      n_pass   = 0;
    sample_t exp_q[$];
    sample_t pend[$];
    int      m_cnt = 0;
    int      start_q[$];
    int      n_starts = 0;
    int      frames_out = 0;
    int      beat_idx = 0;
    int      last_start = -1;
    int      last_beat_cyc = -1;
    int      dq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int start_at(input int i);
        return (i < start_q.size()) ? start_q[i] : -1;
    endfunction

    always @(negedge clk) begin : monitor
        sample_t e;
        if (o_start === 1'b1) begin
            start_q.push_back(cyc);
            last_start = cyc;
            beat_idx   = 0;
            n_starts++;
        end
        if (o_valid === 1'b1) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_re", o_re, e.re);
                check("beat_im", o_im, e.im);
            end
            check("beat_slot", cyc, last_start + 1 + beat_idx);
            beat_idx++;
            if (beat_idx == FRAME_N) begin
                frames_out++;
                last_beat_cyc = cyc;
            end
        end
    end

    task automatic put_beat(input logic [31:0] re, input logic [31:0] im, input logic last);
        int      w = 0;
        sample_t smp;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        while (s_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("beat_accept_wait", s_ready, 1'b1);
        @(posedge clk);
        smp.re = re;
        smp.im = im;
        pend.push_back(smp);
        if (m_cnt == FRAME_N - 1) begin
            foreach (pend[i]) exp_q.push_back(pend[i]);
            pend.delete();
            m_cnt = 0;
        end else if (last) begin
            pend.delete();
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] base, input int n, input int last_at);
        for (int k = 0; k < n; k++) begin
            put_beat(base + 32'(k), ~(base + 32'(k)), k == last_at);
        end
    endtask

    task automatic drop_valid();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_done(output int d);
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        d = cyc;
    endtask

    task automatic wait_frames(input int target);
        int w = 0;
        while (frames_out < target && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("frame_arrival", frames_out >= target, 1'b1);
    endtask

    task automatic serve(input int target);
        int d;
        wait_frames(target);
        repeat (3) @(negedge clk);
        pulse_done(d);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int e_cyc, d_cyc, t_cyc, l_cyc, n0, f0, w;

        // Reset state
        i_rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; i_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_o_start", o_start, 1'b0);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_busy", o_busy, 1'b0);
        check("rst_o_frame_err", o_frame_err, 1'b0);
        check("rst_o_timeout", o_timeout, 1'b0);
        check("rst_o_re", o_re, 32'h0);
        check("rst_o_im", o_im, 32'h0);
        i_rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1'b1);

        // Single frame of 1.0 .. 8.0
        n0 = n_starts; f0 = frames_out;
        for (int k = 0; k < 8; k++) put_beat(FLOATS[k], 32'(k), k == 7);
        e_cyc = cyc;
        drop_valid();
        repeat (14) @(negedge clk);
        check("single_start_count", n_starts, n0 + 1);
        check("single_start_cycle", start_at(n0), e_cyc + 1);
        check("single_frames", frames_out, f0 + 1);
        check("single_last_beat_cycle", last_beat_cyc, e_cyc + 9);
        check("single_busy_wait", o_busy, 1'b1);
        pulse_done(d_cyc);
        check("single_busy_release", o_busy, 1'b0);
        check("single_no_timeout", o_timeout, 1'b0);

        // Three back-to-back frames, done 10 cycles after each frame's last beat
        n0 = n_starts; f0 = frames_out; dq.delete();
        fork
            begin
                feed(32'h1000_0000, 8, 7);
                feed(32'h2000_0000, 8, 7);
                check("b2b_ready_low_both_full", s_ready, 1'b0);
                feed(32'h3000_0000, 8, 7);
                drop_valid();
            end
            begin
                int d;
                for (int f = 1; f <= 3; f++) begin
                    wait_frames(f0 + f);
                    repeat (10) @(negedge clk);
                    pulse_done(d);
                    dq.push_back(d);
                end
            end
        join
        check("b2b_starts", n_starts, n0 + 3);
        check("b2b_frames", frames_out, f0 + 3);
        check("b2b_gap_1", start_at(n0 + 1), dq[0] + 1);
        check("b2b_gap_2", start_at(n0 + 2), dq[1] + 1);
        check("b2b_idle", o_busy, 1'b0);

        // Framing: early last, then a clean frame, then a missing last
        n0 = n_starts; f0 = frames_out;
        feed(32'h4000_0000, 5, 4);
        drop_valid();
        check("err_short_pulse", o_frame_err, 1'b1);
        @(negedge clk);
        check("err_short_clears", o_frame_err, 1'b0);
        repeat (12) @(negedge clk);
        check("err_short_no_start", n_starts, n0);
        check("err_short_idle", o_busy, 1'b0);
        feed(32'h5000_0000, 8, 7);
        drop_valid();
        check("good_frame_no_err", o_frame_err, 1'b0);
        serve(f0 + 1);
        check("good_frame_start", n_starts, n0 + 1);
        feed(32'h6000_0000, 8, -1);
        drop_valid();
        check("err_long_pulse", o_frame_err, 1'b1);
        serve(f0 + 2);
        check("err_long_start", n_starts, n0 + 2);

        // Timeout with a second frame buffered behind it
        n0 = n_starts; f0 = frames_out;
        feed(32'h7000_0000, 8, 7);
        feed(32'h7100_0000, 8, 7);
        drop_valid();
        w = 0;
        while (o_timeout !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        t_cyc = cyc;
        l_cyc = last_beat_cyc;
        check("timeout_seen", o_timeout, 1'b1);
        check("timeout_window",
              (t_cyc >= l_cyc + DONE_TIMEOUT - 1) && (t_cyc <= l_cyc + DONE_TIMEOUT + 1), 1'b1);
        repeat (2) @(negedge clk);
        check("timeout_next_start", start_at(n0 + 1), t_cyc + 1);
        serve(f0 + 2);
        check("timeout_sticky", o_timeout, 1'b1);
        check("timeout_b_idle", o_busy, 1'b0);

        // Stray done while idle must not disturb the bank pointers
        n0 = n_starts; f0 = frames_out;
        pulse_done(d_cyc);
        repeat (4) @(negedge clk);
        check("stray_done_no_start", n_starts, n0);
        check("stray_done_idle", o_busy, 1'b0);
        feed(32'h7200_0000, 8, 7);
        drop_valid();
        serve(f0 + 1);
        check("after_stray_start", n_starts, n0 + 1);

        // Reset during beat 4 of a frame, with a partial frame also pending
        n0 = n_starts; f0 = frames_out;
        feed(32'h8000_0000, 8, 7);
        e_cyc = cyc;
        feed(32'h8100_0000, 3, -1);
        drop_valid();
        while (cyc < e_cyc + 6) @(negedge clk);
        check("rst_mid_valid", o_valid, 1'b1);
        check("rst_mid_beat4", o_re, 32'h8000_0004);
        i_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid_drop", o_valid, 1'b0);
        check("rst_mid_busy_drop", o_busy, 1'b0);
        check("rst_mid_ready_low", s_ready, 1'b0);
        i_rst = 1'b0;
        exp_q.delete();
        pend.delete();
        m_cnt = 0;
        @(negedge clk);
        check("rst_mid_ready_back", s_ready, 1'b1);
        check("rst_mid_timeout_clear", o_timeout, 1'b0);
        repeat (20) @(negedge clk);
        check("rst_mid_no_restart", n_starts, n0 + 1);
        check("rst_mid_no_frame", frames_out, f0);

        // Clean frame after the mid-operation reset
        f0 = frames_out;
        feed(32'h9000_0000, 8, 7);
        e_cyc = cyc;
        drop_valid();
        serve(f0 + 1);
        check("final_start_cycle", start_at(n0 + 1), e_cyc + 1);
        check("final_idle", o_busy, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
